// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - AHB-Lite SINGLE-transfer master fed by a buffered command queue
//
// Accepts valid/ready commands into a small FIFO and issues them as AHB-Lite
// SINGLE transfers with overlapped address (A) and data (D) phases. One
// response pulse is produced per completed data phase.
//
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_write, cmd_addr, cmd_wdata payload
//   rsp_valid              one-cycle pulse per completed transfer
//   rsp_write/rsp_error    direction and ERROR status of the completed transfer
//   rsp_rdata              last successful read data (held otherwise)
//   busy                   queue non-empty or a bus phase in flight
//   HADDR..HWDATA          AHB-Lite master outputs (registered)
//   HRDATA/HREADY/HRESP    AHB-Lite slave returns
module ahb_lite_cmd_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] XFER_SIZE  = 3'b010
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HSEL,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  cmd_t        fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  cmd_t        head;

  // Pipeline slots. HADDR/HWRITE double as the A-slot address/direction
  // registers; HWDATA doubles as the D-slot write data register.
  logic        a_valid;
  logic [31:0] a_wdata;
  logic        d_valid;
  logic        d_write;

  // Set for the cycle(s) between the first and second ERROR cycle, when the
  // bus must show IDLE and the pending A transfer is withheld.
  logic        err_idle;

  logic        a_load;
  logic        d_from_a;
  logic        a_valid_n;
  logic        err_n;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  assign HSIZE  = XFER_SIZE;
  assign HBURST = 3'b000;
  assign busy   = !fifo_empty || a_valid || d_valid;

  always_comb begin
    // A refills whenever its current transfer has been taken by the slave,
    // or whenever it is empty (an empty slot can load even during a stall).
    // After an error the withheld A transfer was never seen by the slave,
    // so it stays in A instead of moving on to D.
    a_load    = (HREADY && !err_idle) || !a_valid;
    d_from_a  = HREADY && !err_idle && a_valid;
    pop       = a_load && !fifo_empty;
    a_valid_n = a_load ? !fifo_empty : a_valid;
    if (d_valid && HRESP && !HREADY) begin
      err_n = 1'b1;
    end else if (HREADY) begin
      err_n = 1'b0;
    end else begin
      err_n = err_idle;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      a_valid   <= 1'b0;
      a_wdata   <= 32'd0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      err_idle  <= 1'b0;
      HADDR     <= 32'd0;
      HWRITE    <= 1'b0;
      HTRANS    <= TRANS_IDLE;
      HSEL      <= 1'b0;
      HWDATA    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (a_load) begin
        a_valid <= !fifo_empty;
        if (!fifo_empty) begin
          HADDR   <= head.addr;
          HWRITE  <= head.write;
          a_wdata <= head.wdata;
        end
      end

      // D only changes on a completing cycle; while HREADY is low it holds.
      if (HREADY) begin
        d_valid <= d_from_a;
        if (d_from_a) begin
          d_write <= HWRITE;
          HWDATA  <= a_wdata;
        end
      end

      err_idle <= err_n;
      HTRANS   <= (a_valid_n && !err_n) ? TRANS_NONSEQ : TRANS_IDLE;
      HSEL     <= a_valid_n && !err_n;

      rsp_valid <= d_valid && HREADY;
      if (d_valid && HREADY) begin
        rsp_write <= d_write;
        rsp_error <= HRESP;
        if (!d_write && !HRESP) begin
          rsp_rdata <= HRDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - self-checking bench for ahb_lite_cmd_master with memory slave model
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_write, rsp_error, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic        HSEL, HWRITE, HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(.FIFO_DEPTH(4), .XFER_SIZE(3'b010)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HSEL(HSEL), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        pend[$];   // commands waiting to be offered
  cmd_t        expq[$];   // accepted commands awaiting their response
  logic [31:0] smem [logic [31:0]];  // slave memory
  logic [31:0] mmem [logic [31:0]];  // reference model memory
  logic [31:0] last_rdata;

  int n_chk, n_pass, acc_cnt, rsp_cnt, err_idle_cnt;

  // slave model state
  logic        s_dp, s_dw, s_err;
  logic [31:0] s_da;
  int          s_wait, s_eph;
  logic        n_ready, n_resp;
  logic [31:0] n_rdata;
  int          wait_min, wait_max;
  logic        err_en, stall;
  logic [31:0] err_addr;

  // previous-cycle bus view
  logic        p_valid, p_ready, p_resp, p_write;
  logic [1:0]  p_trans;
  logic [31:0] p_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic present();
    if (pend.size() > 0 && HRESETn) begin
      cmd_valid = 1'b1;
      cmd_write = pend[0].w;
      cmd_addr  = pend[0].a;
      cmd_wdata = pend[0].d;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end
  endtask

  // Runs at the negedge: checks what the DUT shows this cycle and computes
  // what the slave and the handshake do at the coming rising edge.
  task automatic observe();
    cmd_t e;
    logic e_err;
    if (!HRESETn) begin
      p_valid = 1'b0;
      s_dp = 1'b0;
      n_ready = 1'b1;
      n_resp = 1'b0;
      return;
    end
    if (rsp_valid) begin
      if (expq.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        e_err = err_en && (e.a == err_addr);
        if (!e_err) begin
          if (e.w) mmem[e.a] = e.d;
          else last_rdata = mmem.exists(e.a) ? mmem[e.a] : 32'd0;
        end
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, e.w});
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, e_err});
        chk("rsp_rdata", rsp_rdata, last_rdata);
        rsp_cnt++;
      end
    end
    if (p_valid && !p_ready) begin
      if (p_resp) begin
        chk("err_idle_htrans", {30'd0, HTRANS}, 32'd0);
        chk("err_idle_hsel", {31'd0, HSEL}, 32'd0);
        err_idle_cnt++;
      end else if (p_trans == 2'b10) begin
        chk("hold_htrans", {30'd0, HTRANS}, {30'd0, p_trans});
        chk("hold_haddr", HADDR, p_addr);
        chk("hold_hwrite", {31'd0, HWRITE}, {31'd0, p_write});
      end
    end
    p_valid = 1'b1;
    p_ready = HREADY;
    p_resp  = HRESP;
    p_trans = HTRANS;
    p_addr  = HADDR;
    p_write = HWRITE;
    if (cmd_valid && cmd_ready && pend.size() > 0) begin
      expq.push_back(pend.pop_front());
      acc_cnt++;
    end
    // slave: completion and address capture at the edge
    if (HREADY) begin
      if (s_dp && s_dw && !HRESP) smem[s_da] = HWDATA;
      if (HTRANS == 2'b10 && HSEL) begin
        s_dp = 1'b1;
        s_dw = HWRITE;
        s_da = HADDR;
        s_wait = int'($urandom_range(wait_max, wait_min));
        s_err = err_en && (HADDR == err_addr);
        s_eph = 0;
      end else begin
        s_dp = 1'b0;
      end
    end
    n_rdata = $urandom;
    n_resp = 1'b0;
    if (stall) begin
      n_ready = 1'b0;
    end else if (!s_dp) begin
      n_ready = 1'b1;
    end else if (s_wait > 0) begin
      n_ready = 1'b0;
      s_wait--;
    end else if (s_err && s_eph == 0) begin
      n_ready = 1'b0;
      n_resp = 1'b1;
      s_eph = 1;
    end else if (s_err) begin
      n_ready = 1'b1;
      n_resp = 1'b1;
    end else begin
      n_ready = 1'b1;
      if (!s_dw) n_rdata = smem.exists(s_da) ? smem[s_da] : 32'd0;
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    observe();
    @(posedge HCLK);
    #1;
    HREADY = n_ready;
    HRESP  = n_resp;
    HRDATA = n_rdata;
    present();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((pend.size() != 0 || expq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, (pend.size() == 0 && expq.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_htrans"}, {30'd0, HTRANS}, 32'd0);
    chk({pfx, "_hsel"}, {31'd0, HSEL}, 32'd0);
    chk({pfx, "_haddr"}, HADDR, 32'd0);
    chk({pfx, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
    chk({pfx, "_hwdata"}, HWDATA, 32'd0);
    chk({pfx, "_hsize"}, {29'd0, HSIZE}, 32'd2);
    chk({pfx, "_hburst"}, {29'd0, HBURST}, 32'd0);
    chk({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({pfx, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
    chk({pfx, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
    chk({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic clear_bench();
    pend.delete();
    expq.delete();
    smem.delete();
    mmem.delete();
    last_rdata = 32'd0;
    s_dp = 1'b0;
    p_valid = 1'b0;
    n_ready = 1'b1;
    n_resp = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    present();
  endtask

  initial begin
    int acc0, rsp0, err0;
    n_chk = 0; n_pass = 0; acc_cnt = 0; rsp_cnt = 0; err_idle_cnt = 0;
    wait_min = 0; wait_max = 0; err_en = 1'b0; err_addr = 32'd0; stall = 1'b0;
    HRDATA = 32'd0;
    clear_bench();
    #1 HRESETn = 1'b0;
    #1 check_reset_vals("rst");
    tick(); tick();
    HRESETn = 1'b1;

    // 1: single write, zero-wait latency
    pend.push_back('{1'b1, 32'd4, 32'd6});
    present();
    tick();                                            // edge 0 accepts
    chk("t1_c0_htrans", {30'd0, HTRANS}, 32'd0);
    chk("t1_c0_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_c1_htrans", {30'd0, HTRANS}, 32'd2);
    chk("t1_c1_hsel", {31'd0, HSEL}, 32'd1);
    chk("t1_c1_haddr", HADDR, 32'd4);
    chk("t1_c1_hwrite", {31'd0, HWRITE}, 32'd1);
    tick();
    chk("t1_c2_hwdata", HWDATA, 32'd6);
    chk("t1_c2_htrans", {30'd0, HTRANS}, 32'd0);
    chk("t1_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_c3_rsp_write", {31'd0, rsp_write}, 32'd1);
    tick();
    chk("t1_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_c4_busy", {31'd0, busy}, 32'd0);

    // 2: read back
    pend.push_back('{1'b0, 32'd4, 32'd0});
    present();
    drain("t2_drain", 50);
    chk("t2_rdata", rsp_rdata, 32'd6);
    chk("t2_rsp_write", {31'd0, rsp_write}, 32'd0);

    // 3: four writes with two wait states each, then read-back
    wait_min = 2; wait_max = 2;
    rsp0 = rsp_cnt;
    for (int i = 0; i < 4; i++) pend.push_back('{1'b1, 32'(i), 32'(i + 16)});
    for (int i = 0; i < 4; i++) pend.push_back('{1'b0, 32'(i), 32'd0});
    present();
    drain("t3_drain", 200);
    chk("t3_nrsp", 32'(rsp_cnt - rsp0), 32'd8);
    chk("t3_last_rdata", rsp_rdata, 32'd19);
    wait_min = 0; wait_max = 0;

    // 4: slave stalls; FIFO plus A slot fill up
    stall = 1'b1;
    tick(); tick();
    acc0 = acc_cnt; rsp0 = rsp_cnt;
    for (int i = 0; i < 6; i++) pend.push_back('{1'b1, 32'(40 + 4 * i), $urandom});
    present();
    for (int i = 0; i < 12; i++) tick();
    chk("t4_accepted", 32'(acc_cnt - acc0), 32'd5);
    chk("t4_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t4_pending", 32'(pend.size()), 32'd1);
    chk("t4_haddr", HADDR, 32'd40);
    chk("t4_htrans", {30'd0, HTRANS}, 32'd2);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    stall = 1'b0;
    drain("t4_drain", 100);
    chk("t4_nrsp", 32'(rsp_cnt - rsp0), 32'd6);

    // 5: ERROR on write 8 with read 12 queued behind it
    err_en = 1'b1; err_addr = 32'd8;
    pend.push_back('{1'b1, 32'd12, 32'h1234});
    present();
    drain("t5_pre_drain", 50);
    rsp0 = rsp_cnt; err0 = err_idle_cnt;
    pend.push_back('{1'b1, 32'd8, 32'hdead});
    pend.push_back('{1'b0, 32'd12, 32'd0});
    present();
    drain("t5_drain", 50);
    chk("t5_nrsp", 32'(rsp_cnt - rsp0), 32'd2);
    chk("t5_idle_cycles", 32'(err_idle_cnt - err0), 32'd1);
    chk("t5_rdata", rsp_rdata, 32'h1234);
    chk("t5_rsp_error", {31'd0, rsp_error}, 32'd0);

    // random traffic against the reference model
    err_addr = 32'd60; wait_min = 0; wait_max = 2;
    rsp0 = rsp_cnt;
    for (int i = 0; i < 40; i++)
      pend.push_back('{1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom});
    present();
    drain("rand_drain", 2000);
    chk("rand_nrsp", 32'(rsp_cnt - rsp0), 32'd40);
    err_en = 1'b0; wait_min = 0; wait_max = 0;

    // 6: asynchronous reset in the middle of a burst of three
    for (int i = 0; i < 3; i++) pend.push_back('{1'b1, 32'(80 + 4 * i), $urandom});
    present();
    tick(); tick(); tick();
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    #2 HRESETn = 1'b0;
    #1 check_reset_vals("t6");
    clear_bench();
    tick(); tick();
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
